// File: rtl/fetch_pc_ctrl.sv
// Instruction-fetch front end: owns the fetch PC, keeps one imem request in
// flight and buffers the returned instruction (or fault) in a single decode slot.
module fetch_pc_ctrl #(
  parameter int                    ADDR_WIDTH = 64,
  parameter int                    INST_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR  = 64'h0000_0000_8000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [INST_WIDTH-1:0] imem_rsp_data,
  input  logic                  imem_rsp_err,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  if_valid,
  input  logic                  if_ready,
  output logic [ADDR_WIDTH-1:0] if_pc,
  output logic [INST_WIDTH-1:0] if_inst,
  output logic                  if_fault,
  output logic [1:0]            dbg_state
);

  // Handshakes: a transfer happens on a rising clk edge where valid and ready are
  // both high; valid never depends on ready; payload holds while valid && !ready,
  // except that a redirect may retarget a request memory has not accepted yet.

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_IDLE = 2'd2
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  kill;
  logic                  slot_free;
  logic                  pc_aligned;
  logic                  req_fire;
  logic [ADDR_WIDTH-1:0] pc_seq;

  assign slot_free      = !if_valid || if_ready;
  assign pc_aligned     = (pc[1:0] == 2'b00);
  assign imem_req_valid = rst && (state == ST_REQ) && slot_free && pc_aligned;
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign pc_seq         = pc + ADDR_WIDTH'(4);
  assign dbg_state      = state;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_REQ;
      pc       <= BOOT_ADDR;
      kill     <= 1'b0;
      if_valid <= 1'b0;
      if_pc    <= BOOT_ADDR;
      if_inst  <= '0;
      if_fault <= 1'b0;
    end else begin
      if (if_valid && if_ready) begin
        if_valid <= 1'b0;
      end
      if (redirect_valid) begin
        pc       <= redirect_pc;
        if_valid <= 1'b0;
        // An accepted old-PC request still owes a response; park in WAIT to drop it.
        case (state)
          ST_REQ: begin
            if (req_fire) begin
              state <= ST_WAIT;
              kill  <= 1'b1;
            end
          end
          ST_WAIT: begin
            if (imem_rsp_valid) begin
              state <= ST_REQ;
            end else begin
              kill <= 1'b1;
            end
          end
          default: state <= ST_REQ;
        endcase
      end else begin
        case (state)
          ST_REQ: begin
            if (req_fire) begin
              state <= ST_WAIT;
              kill  <= 1'b0;
            end else if (!pc_aligned && slot_free) begin
              if_valid <= 1'b1;
              if_pc    <= pc;
              if_inst  <= '0;
              if_fault <= 1'b1;
              state    <= ST_IDLE;
            end
          end
          ST_WAIT: begin
            if (imem_rsp_valid) begin
              if (kill) begin
                state <= ST_REQ;
              end else if (imem_rsp_err) begin
                if_valid <= 1'b1;
                if_pc    <= pc;
                if_inst  <= '0;
                if_fault <= 1'b1;
                state    <= ST_IDLE;
              end else begin
                if_valid <= 1'b1;
                if_pc    <= pc;
                if_inst  <= imem_rsp_data;
                if_fault <= 1'b0;
                pc       <= pc_seq;
                state    <= ST_REQ;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Bench for fetch_pc_ctrl: directed scenarios plus randomized traffic checked
// against a program-order fetch-stream model.
`timescale 1ns/1ps
module tb_fetch_pc_ctrl;

  localparam logic [63:0] BOOT   = 64'h0000_0000_8000_0000;
  localparam logic [1:0]  S_REQ  = 2'd0;
  localparam logic [1:0]  S_WAIT = 2'd1;
  localparam logic [1:0]  S_IDLE = 2'd2;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req_valid, imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid, imem_rsp_err;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        if_valid, if_ready, if_fault;
  logic [63:0] if_pc;
  logic [31:0] if_inst;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  fetch_pc_ctrl dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .imem_rsp_err(imem_rsp_err),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc),
    .if_inst(if_inst), .if_fault(if_fault), .dbg_state(dbg_state)
  );

  // ---------------- counters / checker ----------------
  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- knobs ----------------
  int          ready_pct = 100, dec_pct = 0, redir_pct = 0, spur_pct = 0;
  int          rst_pm = 0, lat_min = 1, lat_max = 1;
  bit          hold_rst = 1'b1;
  bit          force_redir = 1'b0;
  logic [63:0] force_pc = '0;
  bit          err_addr_en = 1'b0;
  logic [63:0] err_addr = 64'h0000_0000_8000_0008;
  bit          rand_err = 1'b0;

  // ---------------- memory contents ----------------
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == BOOT) return 32'h0000_0013;
    return (a[31:0] * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic bit err_at(input logic [63:0] a);
    return (err_addr_en && a == err_addr) || (rand_err && a[6:2] == 5'd7);
  endfunction

  function automatic logic [63:0] rand_pc();
    logic [63:0] p;
    int sel;
    sel = $urandom_range(0, 15);
    if (sel == 0) p = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 3) * 4);
    else          p = BOOT + 64'($urandom_range(0, 255) * 4);
    if ($urandom_range(0, 7) == 0) p[1:0] = 2'($urandom_range(1, 3));
    return p;
  endfunction

  // ---------------- monitor-sampled state ----------------
  bit          mon_rst = 1'b0, mon_hs = 1'b0;
  logic [63:0] mon_addr = '0;
  bit          busy = 1'b0;
  int          cnt = 0;
  logic [63:0] busy_addr = '0;

  // ---------------- driver: memory, decode, redirect, reset ----------------
  task automatic step();
    @(posedge clk);
    #1;
    rst = !(hold_rst || ($urandom_range(0, 999) < rst_pm));
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    imem_rsp_err   = 1'($urandom_range(0, 1));
    if (!mon_rst) begin
      busy = 1'b0;
    end else begin
      if (mon_hs) begin
        busy      = 1'b1;
        cnt       = $urandom_range(lat_min, lat_max);
        busy_addr = mon_addr;
      end
      if (busy) begin
        cnt--;
        if (cnt == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = mem_word(busy_addr);
          imem_rsp_err   = err_at(busy_addr);
          busy           = 1'b0;
        end
      end else if ($urandom_range(0, 99) < spur_pct) begin
        imem_rsp_valid = 1'b1;  // nothing outstanding: must be ignored
      end
    end
    imem_req_ready = ($urandom_range(0, 99) < ready_pct);
    if_ready       = ($urandom_range(0, 99) < dec_pct);
    if (force_redir) begin
      redirect_valid = 1'b1;
      redirect_pc    = force_pc;
      force_redir    = 1'b0;
    end else begin
      redirect_valid = ($urandom_range(0, 99) < redir_pct);
      redirect_pc    = redirect_valid ? rand_pc() : {$urandom, $urandom};
    end
  endtask

  task automatic wait_slot(input string tag, input int max);
    int n;
    n = 0;
    do begin
      step();
      @(negedge clk);
      n++;
    end while (!if_valid && n < max);
    check_eq({tag, "_timeout"}, if_valid, 1);
  endtask

  task automatic wait_req(input string tag, input int max, input bit no_slot);
    int n;
    n = 0;
    do begin
      step();
      @(negedge clk);
      n++;
      if (no_slot && !imem_req_valid) check_eq({tag, "_no_slot"}, if_valid, 0);
    end while (!imem_req_valid && n < max);
    check_eq({tag, "_timeout"}, imem_req_valid, 1);
  endtask

  // ---------------- scoreboard: program-order fetch stream ----------------
  logic [63:0] exp_pc = BOOT;
  bit          halted = 1'b0;
  bit          exp_fault;
  bit          prev_hold = 1'b0;
  logic [63:0] prev_pc;
  logic [31:0] prev_inst;
  logic        prev_fault;
  int          consumed = 0;

  initial begin
    forever begin
      @(negedge clk);
      mon_rst  = rst;
      mon_hs   = rst && imem_req_valid && imem_req_ready;
      mon_addr = imem_req_addr;
      if (!rst) begin
        exp_pc    = BOOT;
        halted    = 1'b0;
        prev_hold = 1'b0;
      end else begin
        if (prev_hold) begin
          check_eq("hold_valid", if_valid, 1);
          check_eq("hold_pc", if_pc, prev_pc);
          check_eq("hold_inst", if_inst, prev_inst);
          check_eq("hold_fault", if_fault, prev_fault);
        end
        if (if_valid && !if_ready) check_eq("req_while_full", imem_req_valid, 0);
        if (imem_req_valid) check_eq("req_align", imem_req_addr[1:0], 0);
        if (if_valid && if_ready) begin
          exp_fault = (exp_pc[1:0] != 2'b00) || err_at(exp_pc);
          check_eq("slot_halted", halted, 0);
          check_eq("slot_pc", if_pc, exp_pc);
          check_eq("slot_fault", if_fault, exp_fault);
          check_eq("slot_inst", if_inst, exp_fault ? 32'h0 : mem_word(exp_pc));
          consumed++;
          if (exp_fault) halted = 1'b1;
          else           exp_pc = exp_pc + 64'd4;
        end
        if (mon_hs) begin
          check_eq("req_halted", halted, 0);
          check_eq("req_addr", imem_req_addr, exp_pc);
        end
        if (redirect_valid) begin
          exp_pc = redirect_pc;
          halted = 1'b0;
        end
        prev_hold  = if_valid && !if_ready && !redirect_valid;
        prev_pc    = if_pc;
        prev_inst  = if_inst;
        prev_fault = if_fault;
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0; imem_rsp_err = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0; if_ready = 1'b0;
    err_addr_en = 1'b1;
    repeat (3) step();
    @(negedge clk);
    check_eq("rst_req_valid", imem_req_valid, 0);
    check_eq("rst_if_valid", if_valid, 0);
    check_eq("rst_if_pc", if_pc, BOOT);
    check_eq("rst_if_inst", if_inst, 0);
    check_eq("rst_if_fault", if_fault, 0);
    check_eq("rst_state", dbg_state, S_REQ);
    check_eq("rst_req_addr", imem_req_addr, BOOT);

    // boot fetch, 1-cycle memory, decode stalled
    hold_rst = 1'b0;
    step();
    @(negedge clk);
    check_eq("boot_req_valid", imem_req_valid, 1);
    check_eq("boot_req_addr", imem_req_addr, BOOT);
    step();
    @(negedge clk);
    check_eq("wait_req_valid", imem_req_valid, 0);
    check_eq("wait_state", dbg_state, S_WAIT);
    step();
    @(negedge clk);
    check_eq("first_valid", if_valid, 1);
    check_eq("first_pc", if_pc, BOOT);
    check_eq("first_inst", if_inst, 32'h0000_0013);
    repeat (5) begin
      step();
      @(negedge clk);
      check_eq("stall_req_valid", imem_req_valid, 0);
      check_eq("stall_pc", if_pc, BOOT);
    end
    dec_pct = 100;
    step();
    @(negedge clk);
    check_eq("release_req_valid", imem_req_valid, 1);
    check_eq("release_req_addr", imem_req_addr, BOOT + 64'd4);

    // access fault at +8 halts fetch until a redirect
    wait_slot("item1", 20);
    check_eq("item1_pc", if_pc, BOOT + 64'd4);
    wait_slot("fault", 20);
    check_eq("fault_flag", if_fault, 1);
    check_eq("fault_inst", if_inst, 0);
    check_eq("fault_pc", if_pc, BOOT + 64'd8);
    repeat (6) begin
      step();
      @(negedge clk);
      check_eq("idle_req_valid", imem_req_valid, 0);
      check_eq("idle_state", dbg_state, S_IDLE);
    end
    err_addr_en = 1'b0;
    force_redir = 1'b1; force_pc = BOOT;
    step();
    step();
    @(negedge clk);
    check_eq("resume_req_valid", imem_req_valid, 1);
    check_eq("resume_req_addr", imem_req_addr, BOOT);

    // redirect while waiting for a response
    lat_min = 3; lat_max = 3;
    force_redir = 1'b1; force_pc = 64'h0000_0000_8000_0100;
    step();
    @(negedge clk);
    check_eq("wredir_state", dbg_state, S_WAIT);
    wait_req("wredir", 20, 1);
    check_eq("wredir_addr", imem_req_addr, 64'h0000_0000_8000_0100);

    // redirect while the request is stalled, then in the handshake cycle
    ready_pct = 0;
    wait_req("stall", 20, 0);
    check_eq("stall_addr", imem_req_addr, 64'h0000_0000_8000_0104);
    force_redir = 1'b1; force_pc = 64'h0000_0000_8000_0300;
    step();
    step();
    @(negedge clk);
    check_eq("sredir_valid", imem_req_valid, 1);
    check_eq("sredir_addr", imem_req_addr, 64'h0000_0000_8000_0300);
    ready_pct = 100;
    force_redir = 1'b1; force_pc = 64'h0000_0000_8000_0200;
    step();
    @(negedge clk);
    check_eq("hsredir_fire", imem_req_valid && imem_req_ready, 1);
    wait_req("hsredir", 20, 1);
    check_eq("hsredir_addr", imem_req_addr, 64'h0000_0000_8000_0200);

    // misaligned redirect target, then PC wrap-around
    force_redir = 1'b1; force_pc = 64'h0000_0000_8000_0002;
    step();
    wait_slot("misal", 20);
    check_eq("misal_fault", if_fault, 1);
    check_eq("misal_pc", if_pc, 64'h0000_0000_8000_0002);
    check_eq("misal_inst", if_inst, 0);
    force_redir = 1'b1; force_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    wait_req("top", 20, 0);
    check_eq("top_addr", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    wait_req("wrap", 20, 0);
    check_eq("wrap_addr", imem_req_addr, 64'h0);

    // randomized traffic, with random faults and occasional mid-run resets
    hold_rst = 1'b1;
    step();
    rand_err = 1'b1;
    hold_rst = 1'b0;
    for (int ph = 0; ph < 6; ph++) begin
      ready_pct = $urandom_range(30, 100);
      dec_pct   = $urandom_range(20, 100);
      redir_pct = $urandom_range(0, 8);
      spur_pct  = $urandom_range(0, 20);
      lat_min   = 1;
      lat_max   = $urandom_range(1, 4);
      rst_pm    = (ph == 5) ? 10 : 3;
      repeat (1500) step();
    end
    rst_pm = 0; redir_pct = 0;
    step();
    @(negedge clk);
    check_eq("liveness", consumed > 200, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fetch_pc_ctrl.md
Name: fetch_pc_ctrl

Overview:
- Instruction-fetch front end for the Z-RISC-V core.
- Owns the architectural fetch PC and issues one instruction-memory request at a time using a valid/ready request channel and a valid response channel.
- Buffers the returned instruction in a single output slot and presents it to decode with a valid/ready handshake.
- Accepts redirects (branch, jump, trap) from the back end, which kill any in-flight fetch and any buffered instruction.

Parameters:
- ADDR_WIDTH, 64, width of the PC and memory address.
- INST_WIDTH, 32, width of the instruction word.
- BOOT_ADDR, 64'h0000_0000_8000_0000, PC value loaded on reset.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_req_addr  out  ADDR_WIDTH  fetch address; equals the current PC.
- imem_rsp_valid  in  1  response valid for the single outstanding request.
- imem_rsp_data  in  INST_WIDTH  returned instruction.
- imem_rsp_err  in  1  access fault; qualified by imem_rsp_valid.
- redirect_valid  in  1  redirect the fetch PC.
- redirect_pc  in  ADDR_WIDTH  new fetch PC.
- if_valid  out  1  output slot holds an instruction or fault.
- if_ready  in  1  decode consumes the output slot this cycle.
- if_pc  out  ADDR_WIDTH  PC of the output instruction.
- if_inst  out  INST_WIDTH  instruction; 0 when if_fault=1.
- if_fault  out  1  the output slot carries a fetch fault (access error or misaligned PC).

Behaviour:
- All state updates on the posedge of clk. rst=0 at a posedge resets the block.
- Reset values: state=REQ, pc=BOOT_ADDR, kill=0, if_valid=0, if_pc=BOOT_ADDR, if_inst=0, if_fault=0, imem_req_valid=0.
  - imem_req_valid is combinational from the state. It is 0 while rst=0.
  - The first request (addr BOOT_ADDR) is driven in the first cycle after rst goes high.
- Single outstanding request. Single output slot. slot_free = !if_valid | if_ready.
- State REQ:
  - imem_req_valid = slot_free & (pc[1:0]==0). imem_req_addr = pc.
  - imem_req_valid & imem_req_ready: go to WAIT, kill=0.
  - pc[1:0]!=0 and slot_free: no request is issued. Load the slot with if_pc=pc, if_inst=0, if_fault=1, if_valid=1, and go to IDLE.
- State WAIT (imem_req_valid=0):
  - On imem_rsp_valid with kill=0 and err=0: load the slot (if_pc=pc, if_inst=data, if_fault=0, if_valid=1), set pc <= pc+4 modulo 2^ADDR_WIDTH, go to REQ.
  - With err=1: load the slot with the fault (inst 0), leave pc unchanged, go to IDLE.
  - With kill=1: discard the response, go to REQ.
- State IDLE (fetch halted after a fault): no requests are issued. Leaves only on redirect.
- imem_rsp_valid outside WAIT is ignored.
- Output slot: if_valid & if_ready clears if_valid unless the slot is reloaded the same cycle. Slot contents are stable while if_valid=1 and if_ready=0.
- A request is issued only when slot_free, so a response can never overflow the slot.
- Redirect (highest priority, any state):
  - Sets pc <= redirect_pc and if_valid <= 0.
  - The slot is not loaded that cycle.
  - Next state:
    - REQ, if the state was REQ with no handshake this cycle, or the state was IDLE, or the state was WAIT with imem_rsp_valid this cycle.
    - WAIT with kill=1, if the state was WAIT without a response this cycle, or the state was REQ with a handshake this cycle (the accepted old-PC request is dropped when its response arrives).
  - Redirect while REQ is stalled (valid=1, ready=0): imem_req_addr changes to redirect_pc the next cycle. The memory side tolerates this because the request was not yet accepted.
- Throughput: at best one instruction per 2 cycles with zero-latency memory (REQ then WAIT).
- Mid-operation reset: the in-flight request is abandoned. The memory side is reset by the same rst, so no stale response occurs.

Test Plan:
- Reset release, imem_req_ready=1, rsp 1 cycle later with data 32'h00000013 -> request addr 64'h8000_0000 in the first cycle; next cycle if_valid=1, if_pc=64'h8000_0000, if_inst=32'h00000013; next request addr 64'h8000_0004.
- if_ready=0 for 5 cycles while the slot is full -> imem_req_valid=0 throughout and if_* stable; if_ready=1 -> a new request is issued in the same cycle.
- redirect_valid with redirect_pc=64'h8000_0100 while in WAIT, then rsp data 32'hDEADBEEF -> response dropped, if_valid stays 0, next request addr 64'h8000_0100.
- Redirect in the same cycle as the request handshake -> the following response is dropped; the next fetch uses the redirect PC.
- rsp with imem_rsp_err=1 at pc 64'h8000_0008 -> if_fault=1, if_inst=0, if_pc=64'h8000_0008; no further requests until redirect to 64'h8000_0000 resumes fetch.
- redirect_pc=64'h8000_0002 -> no memory request; if_fault=1, if_pc=64'h8000_0002. Separately, pc=64'hFFFF_FFFF_FFFF_FFFC fetch -> next request addr 64'h0.
